// File: rtl/lru_pkg.sv
// Shared definitions for the LRU replacement controller.
//   WAYS   : associativity (one-hot way vectors are WAYS bits wide)
//   IDX_W  : set-index width (2**IDX_W sets)
//   state_e: controller FSM state encoding
package lru_pkg;

    localparam int WAYS  = 8;
    localparam int IDX_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_UPDATE = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/lru_victim_sel.sv
// Combinational hit / victim selection for one set.
//   i_valid      : valid bits of the addressed set
//   i_match      : tag-compare result per way
//   i_lru_flag   : one-hot LRU way reported by the LRU store
//   o_hit        : at least one way both matches and is valid
//   o_hit_way    : lowest-index valid match (one-hot, 0 on miss)
//   o_victim_way : lowest invalid way; else the LRU way when it is one-hot;
//                  else the top way
//   o_multi_hit  : more than one valid match
module lru_victim_sel #(
    parameter int WAYS = lru_pkg::WAYS
) (
    input  logic [WAYS-1:0] i_valid,
    input  logic [WAYS-1:0] i_match,
    input  logic [WAYS-1:0] i_lru_flag,
    output logic            o_hit,
    output logic [WAYS-1:0] o_hit_way,
    output logic [WAYS-1:0] o_victim_way,
    output logic            o_multi_hit
);
    import lru_pkg::*;

    localparam logic [WAYS-1:0] TOP_WAY = {1'b1, {(WAYS-1){1'b0}}};

    logic [WAYS-1:0] vmatch;
    logic [WAYS-1:0] invalid;
    logic            flag_onehot;

    // x & -x isolates the lowest set bit, which is the lowest-index way.
    always_comb begin
        vmatch       = i_valid & i_match;
        invalid      = ~i_valid;
        flag_onehot  = (i_lru_flag != '0) &&
                       ((i_lru_flag & (i_lru_flag - WAYS'(1))) == '0);
        o_hit        = (vmatch != '0);
        o_multi_hit  = ((vmatch & (vmatch - WAYS'(1))) != '0);
        o_hit_way    = vmatch & (~vmatch + WAYS'(1));
        if (invalid != '0) begin
            o_victim_way = invalid & (~invalid + WAYS'(1));
        end else if (flag_onehot) begin
            o_victim_way = i_lru_flag;
        end else begin
            o_victim_way = TOP_WAY;
        end
    end

endmodule

// File: rtl/lru_replace_ctrl.sv
// Cache lookup / refill / LRU-update sequencer with per-set valid bits.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   i_req_valid / o_req_ready     : lookup request handshake (ready only in IDLE)
//   i_req_addr_7, i_req_match_8   : set index and tag-compare vector, sampled on accept
//   o_lru_addr_7, i_lru_flag_8    : LRU store address and its one-hot LRU way
//   o_lru_update, o_lru_hit_sig,
//   o_lru_hit_way_8               : one-cycle LRU write (promote way, or rotate)
//   o_refill_valid/way/addr,
//   i_refill_done                 : refill request held until done
//   o_resp_valid/hit/way_8,
//   i_resp_ready                  : response held until consumed
//   o_multi_hit_err               : pulse in LOOKUP on more than one valid match
module lru_replace_ctrl #(
    parameter int WAYS  = lru_pkg::WAYS,
    parameter int IDX_W = lru_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [IDX_W-1:0] i_req_addr_7,
    input  logic [WAYS-1:0]  i_req_match_8,
    output logic [IDX_W-1:0] o_lru_addr_7,
    output logic [WAYS-1:0]  o_lru_hit_way_8,
    output logic             o_lru_hit_sig,
    output logic             o_lru_update,
    input  logic [WAYS-1:0]  i_lru_flag_8,
    output logic             o_refill_valid,
    output logic [WAYS-1:0]  o_refill_way_8,
    output logic [IDX_W-1:0] o_refill_addr_7,
    input  logic             i_refill_done,
    output logic             o_resp_valid,
    output logic             o_resp_hit,
    output logic [WAYS-1:0]  o_resp_way_8,
    input  logic             i_resp_ready,
    output logic             o_multi_hit_err
);
    import lru_pkg::*;

    localparam int SETS = 1 << IDX_W;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [WAYS-1:0]  match_q, match_d;
    logic [WAYS-1:0]  way_q, way_d;
    logic             hit_q, hit_d;
    // promote_q: the LRU write names a way (hit or fill of an empty way);
    // otherwise the LRU store simply rotates its current LRU way.
    logic             promote_q, promote_d;
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_row;
    logic [WAYS-1:0]  valid_row_d;
    logic             set_valid;
    logic             accept;

    logic             sel_hit;
    logic             sel_multi;
    logic [WAYS-1:0]  sel_hit_way;
    logic [WAYS-1:0]  sel_victim_way;

    assign valid_row = valid_q[addr_q];
    assign accept    = i_req_valid && o_req_ready;

    lru_victim_sel #(.WAYS(WAYS)) u_sel (
        .i_valid      (valid_row),
        .i_match      (match_q),
        .i_lru_flag   (i_lru_flag_8),
        .o_hit        (sel_hit),
        .o_hit_way    (sel_hit_way),
        .o_victim_way (sel_victim_way),
        .o_multi_hit  (sel_multi)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = sel_hit ? ST_UPDATE : ST_REFILL;
            ST_REFILL: if (i_refill_done) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_RESP;
            ST_RESP:   if (i_resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request capture and lookup result; outputs are gated by state, so
    // these registers need no reset.
    always_comb begin
        addr_d      = addr_q;
        match_d     = match_q;
        way_d       = way_q;
        hit_d       = hit_q;
        promote_d   = promote_q;
        if (accept) begin
            addr_d  = i_req_addr_7;
            match_d = i_req_match_8;
        end
        if (state_q == ST_LOOKUP) begin
            hit_d     = sel_hit;
            way_d     = sel_hit ? sel_hit_way : sel_victim_way;
            promote_d = sel_hit || (valid_row != '1);
        end
        set_valid   = (state_q == ST_REFILL) && i_refill_done;
        valid_row_d = valid_row | way_q;
    end

    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        match_q   <= match_d;
        way_q     <= way_d;
        hit_q     <= hit_d;
        promote_q <= promote_d;
    end

    // Valid bits are only ever set by a completed refill; reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (set_valid) begin
            valid_q[addr_q] <= valid_row_d;
        end
    end

    // Output logic
    always_comb begin
        o_req_ready     = 1'b0;
        o_lru_addr_7    = '0;
        o_refill_addr_7 = '0;
        o_lru_hit_way_8 = '0;
        o_lru_hit_sig   = 1'b0;
        o_lru_update    = 1'b0;
        o_refill_valid  = 1'b0;
        o_refill_way_8  = '0;
        o_resp_valid    = 1'b0;
        o_resp_hit      = 1'b0;
        o_resp_way_8    = '0;
        o_multi_hit_err = 1'b0;
        if (state_q != ST_IDLE) begin
            o_lru_addr_7    = addr_q;
            o_refill_addr_7 = addr_q;
        end
        case (state_q)
            ST_IDLE:   o_req_ready = !rst;
            ST_LOOKUP: o_multi_hit_err = sel_multi;
            ST_REFILL: begin
                o_refill_valid = 1'b1;
                o_refill_way_8 = way_q;
            end
            ST_UPDATE: begin
                o_lru_update    = 1'b1;
                o_lru_hit_sig   = promote_q;
                o_lru_hit_way_8 = promote_q ? way_q : '0;
            end
            ST_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_hit   = hit_q;
                o_resp_way_8 = way_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Bench for lru_replace_ctrl: directed scenarios followed by random requests,
// all checked against a per-set valid-bit model of the replacement rules.
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_lru_replace_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [6:0] i_req_addr_7;
    logic [7:0] i_req_match_8;
    logic [6:0] o_lru_addr_7;
    logic [7:0] o_lru_hit_way_8;
    logic       o_lru_hit_sig;
    logic       o_lru_update;
    logic [7:0] i_lru_flag_8;
    logic       o_refill_valid;
    logic [7:0] o_refill_way_8;
    logic [6:0] o_refill_addr_7;
    logic       i_refill_done;
    logic       o_resp_valid;
    logic       o_resp_hit;
    logic [7:0] o_resp_way_8;
    logic       i_resp_ready;
    logic       o_multi_hit_err;

    int checks   = 0;
    int failures = 0;

    // Model: which ways of each set hold a line.
    bit [7:0] vm [128];

    lru_replace_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_addr_7    (i_req_addr_7),
        .i_req_match_8   (i_req_match_8),
        .o_lru_addr_7    (o_lru_addr_7),
        .o_lru_hit_way_8 (o_lru_hit_way_8),
        .o_lru_hit_sig   (o_lru_hit_sig),
        .o_lru_update    (o_lru_update),
        .i_lru_flag_8    (i_lru_flag_8),
        .o_refill_valid  (o_refill_valid),
        .o_refill_way_8  (o_refill_way_8),
        .o_refill_addr_7 (o_refill_addr_7),
        .i_refill_done   (i_refill_done),
        .o_resp_valid    (o_resp_valid),
        .o_resp_hit      (o_resp_hit),
        .o_resp_way_8    (o_resp_way_8),
        .i_resp_ready    (i_resp_ready),
        .o_multi_hit_err (o_multi_hit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 128; s++) vm[s] = '0;
    endtask

    // Expected outcome of a lookup, from the replacement rules.
    task automatic model_lookup(input logic [6:0] a, input logic [7:0] m, input logic [7:0] f,
                                output logic hit, output logic [7:0] way,
                                output logic multi, output logic promote);
        int first = -1;
        int cnt   = 0;
        int inv   = -1;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && vm[a][i]) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        hit   = (first >= 0);
        multi = (cnt > 1);
        if (hit) begin
            way     = 8'(1 << first);
            promote = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) if (!vm[a][i] && inv < 0) inv = i;
            if (inv >= 0) begin
                way     = 8'(1 << inv);
                promote = 1'b1;
            end else if ($countones(f) == 1) begin
                way     = f;
                promote = 1'b0;
            end else begin
                way     = 8'h80;
                promote = 1'b0;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        `CHK("req_ready_wait", o_req_ready, 1'b1);
    endtask

    task automatic check_quiet_reset(input string tag);
        `CHK({tag, "_lru_addr"}, o_lru_addr_7, 7'h0);
        `CHK({tag, "_lru_way"}, o_lru_hit_way_8, 8'h0);
        `CHK({tag, "_lru_sig"}, o_lru_hit_sig, 1'b0);
        `CHK({tag, "_lru_upd"}, o_lru_update, 1'b0);
        `CHK({tag, "_refill_valid"}, o_refill_valid, 1'b0);
        `CHK({tag, "_refill_way"}, o_refill_way_8, 8'h0);
        `CHK({tag, "_refill_addr"}, o_refill_addr_7, 7'h0);
        `CHK({tag, "_resp_valid"}, o_resp_valid, 1'b0);
        `CHK({tag, "_resp_hit"}, o_resp_hit, 1'b0);
        `CHK({tag, "_resp_way"}, o_resp_way_8, 8'h0);
        `CHK({tag, "_multi"}, o_multi_hit_err, 1'b0);
    endtask

    // Full transaction; rdly / sdly = extra cycles before refill_done / resp_ready.
    task automatic do_req(input logic [6:0] a, input logic [7:0] m, input logic [7:0] f,
                          input int rdly, input int sdly);
        logic       eh, emul, eprom;
        logic [7:0] ew;
        model_lookup(a, m, f, eh, ew, emul, eprom);
        wait_ready();
        i_req_valid   = 1'b1;
        i_req_addr_7  = a;
        i_req_match_8 = m;
        i_lru_flag_8  = f;
        @(negedge clk);
        // LOOKUP: request inputs are scrambled to show they are not re-sampled
        i_req_valid   = 1'b0;
        i_req_addr_7  = 7'($urandom);
        i_req_match_8 = 8'($urandom);
        `CHK("lookup_ready", o_req_ready, 1'b0);
        `CHK("lookup_lru_addr", o_lru_addr_7, a);
        `CHK("lookup_refill_addr", o_refill_addr_7, a);
        `CHK("lookup_multi_err", o_multi_hit_err, emul);
        `CHK("lookup_lru_upd", o_lru_update, 1'b0);
        `CHK("lookup_refill_valid", o_refill_valid, 1'b0);
        `CHK("lookup_resp_valid", o_resp_valid, 1'b0);
        @(negedge clk);
        i_lru_flag_8 = 8'($urandom);
        if (!eh) begin
            for (int d = 0; d <= rdly; d++) begin
                `CHK("refill_valid", o_refill_valid, 1'b1);
                `CHK("refill_way", o_refill_way_8, ew);
                `CHK("refill_addr", o_refill_addr_7, a);
                `CHK("refill_lru_upd", o_lru_update, 1'b0);
                `CHK("refill_lru_way", o_lru_hit_way_8, 8'h0);
                `CHK("refill_multi_err", o_multi_hit_err, 1'b0);
                if (d == rdly) i_refill_done = 1'b1;
                @(negedge clk);
            end
            i_refill_done = 1'b0;
            vm[a] = vm[a] | ew;
        end
        // UPDATE
        `CHK("upd_strobe", o_lru_update, 1'b1);
        `CHK("upd_hit_sig", o_lru_hit_sig, eprom);
        `CHK("upd_hit_way", o_lru_hit_way_8, eprom ? ew : 8'h00);
        `CHK("upd_lru_addr", o_lru_addr_7, a);
        `CHK("upd_refill_valid", o_refill_valid, 1'b0);
        `CHK("upd_resp_valid", o_resp_valid, 1'b0);
        `CHK("upd_multi_err", o_multi_hit_err, 1'b0);
        @(negedge clk);
        for (int d = 0; d <= sdly; d++) begin
            `CHK("resp_valid", o_resp_valid, 1'b1);
            `CHK("resp_hit", o_resp_hit, eh);
            `CHK("resp_way", o_resp_way_8, ew);
            `CHK("resp_lru_upd", o_lru_update, 1'b0);
            `CHK("resp_lru_way", o_lru_hit_way_8, 8'h0);
            `CHK("resp_ready_low", o_req_ready, 1'b0);
            if (d == sdly) i_resp_ready = 1'b1;
            @(negedge clk);
        end
        i_resp_ready = 1'b0;
        `CHK("idle_ready", o_req_ready, 1'b1);
        `CHK("idle_resp_valid", o_resp_valid, 1'b0);
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] rm, rf;
        rst           = 1'b1;
        i_req_valid   = 1'b0;
        i_req_addr_7  = '0;
        i_req_match_8 = '0;
        i_lru_flag_8  = '0;
        i_refill_done = 1'b0;
        i_resp_ready  = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_quiet_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1) begin
            failures++;
            $error("FAIL post_reset_ready observed=0x%0h expected=0x1", o_req_ready);
        end

        // Empty set: invalid way 0 chosen ahead of the LRU flag
        do_req(7'd5, 8'h00, 8'h01, 0, 0);
        // Fill the rest of set 5 (ways 1..7), with some refill/resp stalls
        for (int w = 1; w < 8; w++) do_req(7'd5, 8'h00, 8'h01, w % 3, w % 2);
        // Hit on way 2, zero stall: 4-cycle latency checked by fixed timing
        do_req(7'd5, 8'h04, 8'h01, 0, 0);
        // Match on an invalid way in an empty set is a miss
        do_req(7'd9, 8'h01, 8'h00, 0, 0);
        for (int w = 1; w < 8; w++) do_req(7'd9, 8'h00, 8'h00, 0, 0);
        // Full set: LRU flag victim, then zero and multi-bit flags fall back to top way
        do_req(7'd9, 8'h00, 8'h10, 1, 0);
        do_req(7'd9, 8'h00, 8'h00, 0, 0);
        do_req(7'd9, 8'h00, 8'h22, 0, 2);
        // Multiple valid matches: lowest wins with error pulse
        do_req(7'd9, 8'h0A, 8'h01, 0, 0);

        // Reset during REFILL
        wait_ready();
        i_req_valid   = 1'b1;
        i_req_addr_7  = 7'd3;
        i_req_match_8 = 8'h00;
        i_lru_flag_8  = 8'h00;
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_refill_valid !== 1'b1) begin
            failures++;
            $error("FAIL abort_refill_valid_before observed=0x%0h expected=0x1", o_refill_valid);
        end
        rst = 1'b1;
        #1;
        model_clear();
        check_quiet_reset("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1) begin
            failures++;
            $error("FAIL abort_ready_after observed=0x%0h expected=0x1", o_req_ready);
        end
        // Set 5 was full before reset; now its way 0 is the victim again
        do_req(7'd5, 8'h04, 8'h80, 0, 0);

        // Random traffic over a few sets
        for (int k = 0; k < 80; k++) begin
            ra = 7'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rm = 8'h00;
                1:       rm = 8'(1 << $urandom_range(0, 7));
                2:       rm = 8'($urandom);
                default: rm = 8'hFF;
            endcase
            case ($urandom_range(0, 2))
                0:       rf = 8'h00;
                1:       rf = 8'(1 << $urandom_range(0, 7));
                default: rf = 8'($urandom);
            endcase
            do_req(ra, rm, rf, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            checks++;
            if (o_lru_update !== 1'b0) begin
                failures++;
                $error("FAIL rand_idle_lru_upd observed=0x%0h expected=0x0", o_lru_update);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`undef CHK
